// File: rtl/multi_bbox_pkg.sv
// rtl/multi_bbox_pkg.sv - shared widths, empty-state constants and range helper for the bounding-box extractor
package multi_bbox_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int CNT_W_DEF   = 20;

  // Constants are kept at the widest coordinate supported and sliced by users.
  localparam int COORD_MAX_W = 32;
  localparam logic [COORD_MAX_W-1:0] COORD_EMPTY_MIN = '1;
  localparam logic [COORD_MAX_W-1:0] COORD_EMPTY_MAX = '0;

  function automatic logic in_range(input logic [COORD_MAX_W-1:0] v,
                                    input logic [COORD_MAX_W-1:0] lo,
                                    input logic [COORD_MAX_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bbox_channel_acc.sv
// rtl/bbox_channel_acc.sv - per-channel min/max/count accumulator, frame latch and border overlay
module bbox_channel_acc
  import multi_bbox_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MIN_PIXELS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               frame_start,
  input  logic               hit,
  input  logic               de,
  input  logic [COORD_W-1:0] c_w,
  input  logic [COORD_W-1:0] c_h,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_max,
  output logic [CNT_W-1:0]   pix_cnt,
  output logic               box_valid,
  output logic               border
);

  localparam logic [COORD_W-1:0] EMPTY_MIN = COORD_EMPTY_MIN[COORD_W-1:0];
  localparam logic [COORD_W-1:0] EMPTY_MAX = COORD_EMPTY_MAX[COORD_W-1:0];
  localparam logic [CNT_W-1:0]   CNT_SAT   = '1;
  localparam logic [CNT_W-1:0]   CNT_MIN   = CNT_W'(MIN_PIXELS);

  logic [COORD_W-1:0] acc_x_min;
  logic [COORD_W-1:0] acc_y_min;
  logic [COORD_W-1:0] acc_x_max;
  logic [COORD_W-1:0] acc_y_max;
  logic [CNT_W-1:0]   acc_cnt;
  logic               acc_valid;
  logic               on_col_edge;
  logic               on_row_edge;
  logic               border_next;

  assign acc_valid = (acc_cnt >= CNT_MIN);

  // Outline test against the box latched from the previous frame.
  always_comb begin
    on_col_edge = in_range(COORD_MAX_W'(c_h), COORD_MAX_W'(y_min), COORD_MAX_W'(y_max)) &&
                  ((c_w == x_min) || (c_w == x_max));
    on_row_edge = in_range(COORD_MAX_W'(c_w), COORD_MAX_W'(x_min), COORD_MAX_W'(x_max)) &&
                  ((c_h == y_min) || (c_h == y_max));
    border_next = box_valid && de && (on_col_edge || on_row_edge);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_x_min <= EMPTY_MIN;
      acc_y_min <= EMPTY_MIN;
      acc_x_max <= EMPTY_MAX;
      acc_y_max <= EMPTY_MAX;
      acc_cnt   <= '0;
      x_min     <= '0;
      y_min     <= '0;
      x_max     <= '0;
      y_max     <= '0;
      pix_cnt   <= '0;
      box_valid <= 1'b0;
      border    <= 1'b0;
    end else if (ce) begin
      border <= border_next;
      if (frame_start) begin
        // Invalid boxes report zero coordinates but keep their count.
        x_min     <= acc_valid ? acc_x_min : '0;
        y_min     <= acc_valid ? acc_y_min : '0;
        x_max     <= acc_valid ? acc_x_max : '0;
        y_max     <= acc_valid ? acc_y_max : '0;
        pix_cnt   <= acc_cnt;
        box_valid <= acc_valid;
        acc_x_min <= EMPTY_MIN;
        acc_y_min <= EMPTY_MIN;
        acc_x_max <= EMPTY_MAX;
        acc_y_max <= EMPTY_MAX;
        acc_cnt   <= '0;
      end else if (hit) begin
        if (c_w < acc_x_min) acc_x_min <= c_w;
        if (c_h < acc_y_min) acc_y_min <= c_h;
        if (c_w > acc_x_max) acc_x_max <= c_w;
        if (c_h > acc_y_max) acc_y_max <= c_h;
        if (acc_cnt != CNT_SAT) acc_cnt <= acc_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_bounding_box.sv
// rtl/multi_bounding_box.sv - per-frame bounding boxes for NUM_CH mask channels with border overlay
module multi_bounding_box
  import multi_bbox_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MIN_PIXELS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      de,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic [NUM_CH-1:0]         mask,
  output logic [NUM_CH*COORD_W-1:0] x_min,
  output logic [NUM_CH*COORD_W-1:0] y_min,
  output logic [NUM_CH*COORD_W-1:0] x_max,
  output logic [NUM_CH*COORD_W-1:0] y_max,
  output logic [NUM_CH*CNT_W-1:0]   pix_cnt,
  output logic [NUM_CH-1:0]         box_valid,
  output logic                      frame_done,
  output logic [COORD_W-1:0]        c_w,
  output logic [COORD_W-1:0]        c_h,
  output logic [NUM_CH-1:0]         border,
  output logic                      de_o,
  output logic                      hsync_o,
  output logic                      vsync_o
);

  localparam logic [COORD_W-1:0] W_LIM = COORD_W'(IMG_W);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(IMG_H);

  logic de_prev;
  logic vsync_prev;
  logic frame_start;
  logic in_img;

  assign frame_start = vsync && !vsync_prev;
  // The boundary cycle never contributes a pixel, even with de high.
  assign in_img = de && !frame_start && (c_w < W_LIM) && (c_h < H_LIM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      de_prev    <= 1'b0;
      vsync_prev <= 1'b0;
      frame_done <= 1'b0;
      c_w        <= '0;
      c_h        <= '0;
      de_o       <= 1'b0;
      hsync_o    <= 1'b0;
      vsync_o    <= 1'b0;
    end else if (ce) begin
      de_prev    <= de;
      vsync_prev <= vsync;
      frame_done <= frame_start;
      de_o       <= de;
      hsync_o    <= hsync;
      vsync_o    <= vsync;
      if (frame_start) begin
        c_w <= '0;
        c_h <= '0;
      end else if (de) begin
        if (c_w != W_LIM) c_w <= c_w + COORD_W'(1);
      end else if (de_prev) begin
        c_w <= '0;
        if (c_h != H_LIM) c_h <= c_h + COORD_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bbox_channel_acc #(
      .COORD_W   (COORD_W),
      .CNT_W     (CNT_W),
      .MIN_PIXELS(MIN_PIXELS)
    ) u_acc (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .frame_start(frame_start),
      .hit        (in_img && mask[i]),
      .de         (de),
      .c_w        (c_w),
      .c_h        (c_h),
      .x_min      (x_min[i*COORD_W +: COORD_W]),
      .y_min      (y_min[i*COORD_W +: COORD_W]),
      .x_max      (x_max[i*COORD_W +: COORD_W]),
      .y_max      (y_max[i*COORD_W +: COORD_W]),
      .pix_cnt    (pix_cnt[i*CNT_W +: CNT_W]),
      .box_valid  (box_valid[i]),
      .border     (border[i])
    );
  end

endmodule
